aes_encrypt_iterative: RTL and testbench

Iterative AES-128 encryption core directly downstream of the key-expansion stage. Consumes the 1408-bit expanded key schedule once that stage signals ready. Runs one AES round per clock over a 128-bit plaintext block accepted by valid/ready handshake. Holds the ciphertext until the consumer takes it.

---
 rtl/aes_encrypt_iterative_if.sv | 37 +++
 rtl/aes_encrypt_iterative.sv | 144 ++++++++++++++
 tb/tb_aes_encrypt_iterative.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_encrypt_iterative_if.sv
// Key-schedule, plaintext and ciphertext bundle for aes_encrypt_iterative.
// AES_ENC_KEY_ABORT_EN adds the abort strobe driven by the core.
interface aes_encrypt_iterative_if;
   localparam int unsigned BLK_W = 128;
   localparam int unsigned KEY_W = 1408;

   logic             key_ready;
   logic [KEY_W-1:0] expanded_key;
   logic [BLK_W-1:0] pt_in;
   logic             pt_valid;
   logic             pt_ready;
   logic [BLK_W-1:0] ct_out;
   logic             ct_valid;
   logic             ct_ready;
   logic             busy;
`ifdef AES_ENC_KEY_ABORT_EN
   logic             abort;

   modport master (
      output key_ready, expanded_key, pt_in, pt_valid, ct_ready,
      input  pt_ready, ct_out, ct_valid, busy, abort
   );
   modport slave (
      input  key_ready, expanded_key, pt_in, pt_valid, ct_ready,
      output pt_ready, ct_out, ct_valid, busy, abort
   );
`else
   modport master (
      output key_ready, expanded_key, pt_in, pt_valid, ct_ready,
      input  pt_ready, ct_out, ct_valid, busy
   );
   modport slave (
      input  key_ready, expanded_key, pt_in, pt_valid, ct_ready,
      output pt_ready, ct_out, ct_valid, busy
   );
`endif
endinterface

// File: rtl/aes_encrypt_iterative.sv
// Iterative AES-128 encryptor: one round per clock over a pre-expanded key schedule.
// Optional macro AES_ENC_KEY_ABORT_EN: abandon the block if key_ready drops mid-computation.
module aes_encrypt_iterative #(
   parameter int unsigned NR = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   aes_encrypt_iterative_if.slave bus
);
   localparam int unsigned BLK_W = 128;
   localparam int unsigned CNT_W = $clog2(NR + 1);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 fsm;
   logic [CNT_W-1:0]       rnd;
   logic [BLK_W-1:0]       state_reg;
   logic [BLK_W-1:0]       ct_out;
   logic                   ct_valid;
   logic                   busy;
   logic                   pt_ready_c;
   logic [NR:0][BLK_W-1:0] round_keys;
   logic [BLK_W-1:0]       rk;
   logic [BLK_W-1:0]       sb;
   logic [BLK_W-1:0]       mc;
`ifdef AES_ENC_KEY_ABORT_EN
   logic                   abort;
`endif

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes are packed row 0 in the MSBs.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   assign round_keys = bus.expanded_key;
   assign rk         = round_keys[rnd];

   // SubBytes fused with ShiftRows (row r rotates left by r columns), then MixColumns.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sb[32*c + 8*(3-r) +: 8] = SBOX[state_reg[32*((c+r)%4) + 8*(3-r) +: 8]];
      end
      assign mc[32*c +: 32] = mix_column(sb[32*c +: 32]);
   end

   assign pt_ready_c   = rst && (fsm == IDLE) && bus.key_ready;
   assign bus.pt_ready = pt_ready_c;
   assign bus.ct_out   = ct_out;
   assign bus.ct_valid = ct_valid;
   assign bus.busy     = busy;
`ifdef AES_ENC_KEY_ABORT_EN
   assign bus.abort    = abort;
`endif

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm       <= IDLE;
         rnd       <= '0;
         state_reg <= '0;
         ct_out    <= '0;
         ct_valid  <= 1'b0;
         busy      <= 1'b0;
`ifdef AES_ENC_KEY_ABORT_EN
         abort     <= 1'b0;
`endif
      end else begin
`ifdef AES_ENC_KEY_ABORT_EN
         abort <= 1'b0;
`endif
         unique case (fsm)
            IDLE: begin
               if (bus.pt_valid && pt_ready_c) begin
                  state_reg <= bus.pt_in ^ round_keys[0];
                  rnd       <= CNT_W'(1);
                  busy      <= 1'b1;
                  fsm       <= ROUND;
               end
            end
            ROUND: begin
`ifdef AES_ENC_KEY_ABORT_EN
               if (!bus.key_ready) begin
                  rnd   <= '0;
                  busy  <= 1'b0;
                  abort <= 1'b1;
                  fsm   <= IDLE;
               end else
`endif
               if (rnd == CNT_W'(NR)) begin
                  // Final round omits MixColumns.
                  ct_out   <= sb ^ rk;
                  ct_valid <= 1'b1;
                  busy     <= 1'b0;
                  rnd      <= '0;
                  fsm      <= DONE;
               end else begin
                  state_reg <= mc ^ rk;
                  rnd       <= rnd + CNT_W'(1);
               end
            end
            DONE: begin
               if (bus.ct_ready) begin
                  ct_valid <= 1'b0;
                  fsm      <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// Scoreboard bench for aes_encrypt_iterative with a byte-array AES reference model.
module tb_aes_encrypt_iterative;
   localparam int NR = 10;
   localparam logic [127:0] C1_KEY = 128'h0c0d0e0f08090a0b0405060700010203;
   localparam logic [127:0] C1_PT  = 128'hccddeeff8899aabb4455667700112233;
   localparam logic [127:0] C1_CT  = 128'h70b4c55ad8cdb7806a7b043069c4e0d8;

   logic clk;
   logic rst;
   aes_encrypt_iterative_if bus ();

   aes_encrypt_iterative #(.NR(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   logic [7:0]   sbox_m [256];
   logic [127:0] exp_q [$];
   int           acc_q [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Full GF(2^8) product, shift-and-add.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         hi = a[7];
         a  = {a[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_m[x] = s;
      end
   endtask

   function automatic logic [7:0] byte_at(input logic [127:0] b, input int r, input int c);
      return 8'(b >> (32*c + 8*(3-r)));
   endfunction

   function automatic logic [1407:0] expand_key(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] ek;
      rc = 8'h01;
      ek = '0;
      for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32*i));
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) ek |= 1408'(w[i]) << (32*i);
      return ek;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1407:0] ek);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] rk, o;
      rk = 128'(ek);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) s[r][c] = byte_at(pt, r, c) ^ byte_at(rk, r, c);
      for (int n = 1; n <= NR; n++) begin
         rk = 128'(ek >> (128*n));
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = sbox_m[s[r][(c+r)%4]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               if (n < NR)
                  s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03)
                            ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
               else
                  s[r][c] = t[r][c];
               s[r][c] ^= byte_at(rk, r, c);
            end
      end
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) o |= 128'(s[r][c]) << (32*c + 8*(3-r));
      return o;
   endfunction

   // Acceptance monitor: every handshake pushes the reference ciphertext.
   initial forever begin
      @(posedge clk);
      cycle++;
      if (rst && bus.pt_valid && bus.pt_ready) begin
         exp_q.push_back(aes_ref(bus.pt_in, bus.expanded_key));
         acc_q.push_back(cycle);
      end
   end

   // Output monitor: compares each new ciphertext, its latency and the busy window.
   initial begin
      int         busy_cnt;
      logic       prev_valid;
      logic [127:0] e;
      int         a;
      busy_cnt   = 0;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy_cnt   = 0;
            prev_valid = 1'b0;
         end else begin
`ifdef AES_ENC_KEY_ABORT_EN
            if (bus.abort) busy_cnt = 0;
`endif
            if (bus.busy) busy_cnt++;
            if (bus.ct_valid && !prev_valid) begin
               check("sb_pending", 128'(exp_q.size() != 0), 128'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  a = acc_q.pop_front();
                  check("sb_ct", bus.ct_out, e);
                  check("sb_latency", 128'(cycle - a), 128'(NR));
                  check("sb_busy_cycles", 128'(busy_cnt), 128'(NR));
               end
               busy_cnt = 0;
            end
            prev_valid = bus.ct_valid;
         end
      end
   end

   // Called on a falling edge; returns on the falling edge after acceptance.
   task automatic send(input logic [127:0] pt, output int waited);
      logic acc;
      acc          = 1'b0;
      waited       = 0;
      bus.pt_in    = pt;
      bus.pt_valid = 1'b1;
      while (!acc && waited < 60) begin
         @(posedge clk);
         waited++;
         acc = bus.pt_valid && bus.pt_ready;
      end
      check("accept", 128'(acc), 128'(1));
      @(negedge clk);
      bus.pt_valid = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc);
      int n;
      n = 0;
      while (!bus.ct_valid && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check("valid_wait", 128'(bus.ct_valid), 128'(1));
   endtask

   task automatic wait_idle(input bit rnd_ready);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.ct_valid) && n < 200) begin
         bus.ct_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         n++;
      end
      bus.ct_ready = 1'b1;
      check("drain", 128'(n < 200), 128'(1));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1407:0] ek_c1;
      logic [127:0]  held;
      int            w, w2;
      build_sbox();
      ek_c1            = expand_key(C1_KEY);
      rst              = 1'b0;
      bus.key_ready    = 1'b1;
      bus.expanded_key = ek_c1;
      bus.pt_in        = '0;
      bus.pt_valid     = 1'b0;
      bus.ct_ready     = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ct_out", bus.ct_out, 128'h0);
      check("rst_ct_valid", 128'(bus.ct_valid), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_pt_ready", 128'(bus.pt_ready), 128'(0));
      rst = 1'b1;
      @(negedge clk);

      // C.1 vector, then hold it under backpressure.
      send(C1_PT, w);
      wait_valid(40);
      check("c1_ct", bus.ct_out, C1_CT);
      held = bus.ct_out;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_ct_out", bus.ct_out, held);
         check("bp_ct_valid", 128'(bus.ct_valid), 128'(1));
         check("bp_pt_ready", 128'(bus.pt_ready), 128'(0));
      end
      bus.ct_ready = 1'b1;
      @(negedge clk);
      bus.ct_ready = 1'b0;
      check("bp_release_valid", 128'(bus.ct_valid), 128'(0));
      check("bp_release_ready", 128'(bus.pt_ready), 128'(1));

      // Key gating.
      bus.ct_ready  = 1'b1;
      bus.key_ready = 1'b0;
      bus.pt_in     = C1_PT;
      bus.pt_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("gate_pt_ready", 128'(bus.pt_ready), 128'(0));
         check("gate_busy", 128'(bus.busy), 128'(0));
      end
      bus.key_ready = 1'b1;
      send(C1_PT, w);
      check("gate_accept_edges", 128'(w), 128'(1));
      wait_valid(40);
      check("gate_ct", bus.ct_out, C1_CT);
      wait_idle(1'b0);

      // Asynchronous reset in round 5.
      send(C1_PT, w);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_ct_out", bus.ct_out, 128'h0);
      check("midrst_ct_valid", 128'(bus.ct_valid), 128'(0));
      check("midrst_busy", 128'(bus.busy), 128'(0));
      check("midrst_pt_ready", 128'(bus.pt_ready), 128'(0));
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send(C1_PT, w);
      wait_valid(40);
      check("postrst_ct", bus.ct_out, C1_CT);
      wait_idle(1'b0);

      // Back-to-back blocks with the consumer always ready.
      send(128'h0, w);
      send(C1_PT, w2);
      check("b2b_spacing", 128'(w2), 128'(12));
      wait_valid(40);
      check("b2b_second_ct", bus.ct_out, C1_CT);
      wait_idle(1'b0);

      // key_ready drops in round 3.
      send(C1_PT, w);
      repeat (2) @(negedge clk);
      bus.key_ready = 1'b0;
`ifdef AES_ENC_KEY_ABORT_EN
      begin
         int pulses;
         pulses = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.abort) pulses++;
            check("abort_ct_valid", 128'(bus.ct_valid), 128'(0));
         end
         check("abort_pulses", 128'(pulses), 128'(1));
         check("abort_busy", 128'(bus.busy), 128'(0));
         exp_q.delete();
         acc_q.delete();
         bus.key_ready = 1'b1;
         @(negedge clk);
         check("abort_idle_ready", 128'(bus.pt_ready), 128'(1));
      end
`else
      wait_valid(40);
      check("keydrop_ct", bus.ct_out, C1_CT);
      bus.key_ready = 1'b1;
      wait_idle(1'b0);
`endif

      // Random keys and plaintexts with random consumer backpressure.
      for (int i = 0; i < 8; i++) begin
         bus.expanded_key = expand_key({$urandom, $urandom, $urandom, $urandom});
         send({$urandom, $urandom, $urandom, $urandom}, w);
         wait_idle(1'b1);
      end

      repeat (3) @(negedge clk);
      check("sb_empty", 128'(exp_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
